// File: rtl/rom_loader.sv
// Program-memory loader: takes a COUNT / words / CHK byte stream, writes instruction
// words to consecutive ROM addresses and keeps the CPU core held until a load verifies.
module rom_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_BYTES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    w_enable,
    output logic [ADDR_WIDTH-1:0]   w_addr,
    output logic [8*WORD_BYTES-1:0] w_data,
    output logic                    cpu_hold,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int DW    = 8 * WORD_BYTES;
    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_BYTE  = 3'd2,
        S_WRITE = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ADDR_WIDTH-1:0] count_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] addr_inc_s;
    logic [IDX_W-1:0]      idx_r;
    logic [7:0]            chk_r;
    logic [DW-1:0]         word_r;
    logic                  in_ready_r;
    logic                  w_enable_r;
    logic                  cpu_hold_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;
    logic                  accept_s;
    logic                  last_byte_s;
    logic                  last_word_s;

    // in_ready_r already mirrors the current state, so acceptance needs no path back to in_ready
    assign accept_s    = in_valid && in_ready_r;
    assign last_byte_s = (idx_r == IDX_W'(WORD_BYTES - 1));
    assign addr_inc_s  = addr_r + ADDR_WIDTH'(1);
    // Words written equals N once the incremented address wraps onto N (N=0 means a full sweep)
    assign last_word_s = (addr_inc_s == count_r);

    assign in_ready = in_ready_r;
    assign w_enable = w_enable_r;
    assign w_addr   = addr_r;
    assign w_data   = word_r;
    assign cpu_hold = cpu_hold_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_nxt_s = S_COUNT;
                else       state_nxt_s = state_r;
            end
            S_COUNT: begin
                if (accept_s) state_nxt_s = S_BYTE;
                else          state_nxt_s = S_COUNT;
            end
            S_BYTE: begin
                if (accept_s && last_byte_s) state_nxt_s = S_WRITE;
                else                         state_nxt_s = S_BYTE;
            end
            S_WRITE: begin
                if (last_word_s) state_nxt_s = S_CHECK;
                else             state_nxt_s = S_BYTE;
            end
            S_CHECK: begin
                if (accept_s) state_nxt_s = (in_data == chk_r) ? S_DONE : S_ERROR;
                else          state_nxt_s = S_CHECK;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs (outputs decoded from the next state)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            count_r    <= '0;
            addr_r     <= '0;
            idx_r      <= '0;
            chk_r      <= 8'h00;
            word_r     <= '0;
            in_ready_r <= 1'b0;
            w_enable_r <= 1'b0;
            cpu_hold_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == S_COUNT) || (state_nxt_s == S_BYTE) ||
                          (state_nxt_s == S_CHECK);
            busy_r     <= (state_nxt_s == S_COUNT) || (state_nxt_s == S_BYTE) ||
                          (state_nxt_s == S_WRITE) || (state_nxt_s == S_CHECK);
            w_enable_r <= (state_nxt_s == S_WRITE);
            cpu_hold_r <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);

            case (state_r)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        done_r <= 1'b0;
                        err_r  <= 1'b0;
                        addr_r <= '0;
                        idx_r  <= '0;
                        chk_r  <= 8'h00;
                    end
                end
                S_COUNT: begin
                    if (accept_s) begin
                        count_r <= ADDR_WIDTH'(in_data);
                        chk_r   <= chk_r ^ in_data;
                    end
                end
                S_BYTE: begin
                    if (accept_s) begin
                        // Exactly WORD_BYTES shifts per word puts the first byte in the MSB
                        word_r <= (word_r << 8) | DW'(in_data);
                        chk_r  <= chk_r ^ in_data;
                        idx_r  <= last_byte_s ? '0 : idx_r + IDX_W'(1);
                    end
                end
                S_WRITE: begin
                    addr_r <= addr_inc_s;
                end
                S_CHECK: begin
                    if (accept_s) begin
                        if (in_data == chk_r) done_r <= 1'b1;
                        else                  err_r  <= 1'b1;
                    end
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: reset, single word, back-pressure, bad checksum,
// full 256-word wrap and an ignored mid-load start.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        w_enable;
    logic [7:0]  w_addr;
    logic [23:0] w_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  log_addr[$];
    logic [23:0] log_data[$];
    int          ready_in_write = 0;
    logic        busy_watch = 1'b0;
    int          busy_gaps = 0;

    rom_loader #(.ADDR_WIDTH(8), .WORD_BYTES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Write logger and handshake monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (w_enable) begin
            log_addr.push_back(w_addr);
            log_data.push_back(w_data);
            if (in_ready) ready_in_write++;
        end
        if (busy_watch && !busy) busy_gaps++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present a byte and wait (bounded) for the edge that accepts it
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        in_valid = 1'b0;
        tick();
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        ready_in_write = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_w_enable"}, 32'(w_enable), 32'd0);
        check({tag, "_w_addr"},   32'(w_addr),   32'd0);
        check({tag, "_w_data"},   32'(w_data),   32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [7:0] a, input logic [23:0] d);
        if (idx < log_addr.size()) begin
            check({tag, "_addr"}, 32'(log_addr[idx]), 32'(a));
            check({tag, "_data"}, 32'(log_data[idx]), 32'(d));
        end else begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        int bad;

        // Reset state
        #12;
        check_idle_outputs("reset");
        rst = 1'b1;
        tick();

        // Reset in the middle of a load
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_ready", 32'(in_ready), 32'd1);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #2;
        check_idle_outputs("midrst");
        tick();
        rst = 1'b1;
        tick();
        clear_log();

        // Single word load, good checksum
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        check("single_wen_timing", 32'(w_enable), 32'd1);
        check("single_ready_in_write", 32'(in_ready), 32'd0);
        send_byte(8'hDC);
        in_valid = 1'b0;
        check("single_done", 32'(done), 32'd1);
        check("single_err", 32'(err), 32'd0);
        check("single_hold", 32'(cpu_hold), 32'd0);
        tick();
        check("single_busy", 32'(busy), 32'd0);
        check("single_writes", 32'(log_addr.size()), 32'd1);
        check_write("single_w0", 0, 8'h00, 24'hAABBCC);
        clear_log();

        // Back-pressure: valid only every other cycle
        pulse_start();
        send_gap(8'h02);
        send_gap(8'h11);
        send_gap(8'h22);
        send_gap(8'h33);
        send_gap(8'h44);
        send_gap(8'h55);
        send_gap(8'h66);
        send_gap(8'h75);
        check("bp_writes", 32'(log_addr.size()), 32'd2);
        check_write("bp_w0", 0, 8'h00, 24'h112233);
        check_write("bp_w1", 1, 8'h01, 24'h445566);
        check("bp_ready_in_write", 32'(ready_in_write), 32'd0);
        check("bp_done", 32'(done), 32'd1);
        clear_log();

        // Bad checksum
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'h00);
        in_valid = 1'b0;
        tick();
        check("bad_writes", 32'(log_addr.size()), 32'd1);
        check_write("bad_w0", 0, 8'h00, 24'hAABBCC);
        check("bad_err", 32'(err), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_hold", 32'(cpu_hold), 32'd1);
        check("bad_busy", 32'(busy), 32'd0);
        clear_log();
        pulse_start();
        check("restart_err_clear", 32'(err), 32'd0);
        check("restart_hold", 32'(cpu_hold), 32'd1);

        // N=0: 256 words whose data equals the address; XOR of 0..255 is 0
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'(i));
        end
        send_byte(8'h00);
        in_valid = 1'b0;
        tick();
        tick();
        check("wrap_writes", 32'(log_addr.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_addr[i] !== 8'(i) || log_data[i] !== 24'(i)) bad++;
        end
        check("wrap_contents", 32'(bad), 32'd0);
        check("wrap_done", 32'(done), 32'd1);
        check("wrap_err", 32'(err), 32'd0);
        clear_log();

        // Start during BYTE of an N=3 load must be ignored
        pulse_start();
        busy_watch = 1'b1;
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        start = 1'b1;
        send_byte(8'h05);
        start = 1'b0;
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h08);
        send_byte(8'h09);
        check("ign_busy_before_chk", 32'(busy), 32'd1);
        send_byte(8'h02);
        busy_watch = 1'b0;
        in_valid = 1'b0;
        tick();
        check("ign_writes", 32'(log_addr.size()), 32'd3);
        check_write("ign_w0", 0, 8'h00, 24'h010203);
        check_write("ign_w1", 1, 8'h01, 24'h040506);
        check_write("ign_w2", 2, 8'h02, 24'h070809);
        check("ign_busy_gaps", 32'(busy_gaps), 32'd0);
        check("ign_done", 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
# rom_loader

Program-memory writer for the 8-bit CPU. It consumes a byte stream through a valid/ready handshake and assembles 24-bit instruction words. It writes each word into the instruction ROM at consecutive addresses from 0, then checks a trailing XOR checksum. While loading it holds the CPU core stalled through `cpu_hold`. This block is the write side of the same program memory that the fetch path reads through `pc`/`data`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: program address width, matching the 8-bit PC.
- `WORD_BYTES`, default 3: bytes per instruction word. The word is 8*WORD_BYTES bits.

Ports:
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: single-cycle pulse that begins a load.
- `in_data`, in, 8: stream byte.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: loader accepts `in_data` this cycle.
- `w_enable`, out, 1: program-memory write strobe, one cycle wide.
- `w_addr`, out, ADDR_WIDTH: write address.
- `w_data`, out, 8*WORD_BYTES: instruction word.
- `cpu_hold`, out, 1: holds the CPU core. Drives the fetch-enable deassertion.
- `busy`, out, 1: a load is in progress.
- `done`, out, 1: last load completed with a good checksum. Sticky.
- `err`, out, 1: last load failed its checksum. Sticky.

## Operation
- Stream format: one COUNT byte N, then N words of WORD_BYTES bytes each, then one CHK byte.
  - N=0 means 2^ADDR_WIDTH words.
  - Within a word, the first byte goes to `w_data[23:16]`, the next to `[15:8]`, the last to `[7:0]`. The first byte always lands in the MSB.
- A byte is accepted only on a cycle where `in_valid && in_ready`.
- States: IDLE, COUNT, BYTE, WRITE, CHECK, DONE, ERROR.
  - IDLE/DONE/ERROR: a `start` pulse moves to COUNT. It also clears `done`/`err`, zeroes the address counter and byte index, and zeroes the running XOR.
  - COUNT: accepting a byte latches N and XORs the byte into the checksum. Next state is BYTE.
  - BYTE: each accepted byte is shifted into the word register and XORed into the checksum. After byte WORD_BYTES-1 is accepted, the next state is WRITE.
  - WRITE: one cycle. `w_enable`=1, with `w_addr` equal to the current counter and `w_data` equal to the assembled word. The counter then increments, wrapping mod 2^ADDR_WIDTH. If the words written equal N, the next state is CHECK; otherwise BYTE.
  - CHECK: an accepted byte is compared against the running XOR.
    - Equal: go to DONE. Set `done`=1 and drop `cpu_hold`.
    - Not equal: go to ERROR. Set `err`=1 and keep `cpu_hold`=1.
- `in_ready` is 1 only in COUNT, BYTE and CHECK.
- `busy` is 1 in COUNT, BYTE, WRITE and CHECK.
- `cpu_hold` is 1 from the cycle after `start` is accepted until DONE is entered. It stays 1 in ERROR.
- `start` while `busy`=1 is ignored. No restart occurs.
- `in_valid` outside COUNT/BYTE/CHECK is ignored, and no byte is consumed.
- There is no write for a partially received word. `w_enable` never pulses outside WRITE.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `w_enable`=0, `w_addr`=0, `w_data`=0, `cpu_hold`=0, `busy`=0, `done`=0, `err`=0.
- `rst` low at any time returns all state to IDLE immediately, including mid-load. Partially written memory is left as is.
- Timeline from `start` sampled at edge T:
  - COUNT is active from T+1.
  - With back-to-back valid bytes, one byte is accepted per cycle.
  - Each WRITE costs one extra cycle with `in_ready`=0.
  - `w_enable` rises on the cycle after the edge that accepted the last byte of the word.
- A full load of N words with continuous valid takes 1 + N*(WORD_BYTES+1) + 1 cycles after COUNT is entered, landing in DONE or ERROR.
- `done`/`err` update on the edge that accepts CHK. `cpu_hold` falls on the same edge.
- Outputs are all registered. No combinational path from `in_valid` to `in_ready`.

## Test plan
- Reset mid-load: after `start`, feed N=2 and 4 data bytes, then pulse `rst` low. Require all outputs to return to reset values. A later good load still writes from address 0.
- Single word: `start`, then bytes 01, AA, BB, CC, CHK=01^AA^BB^CC=DC.
  - Require exactly one `w_enable` with `w_addr`=00 and `w_data`=AABBCC.
  - Then `done`=1, `err`=0, `cpu_hold`=0.
- Back-pressure: N=2 with `in_valid` toggled every other cycle.
  - Require writes of 112233 at 00 and 445566 at 01.
  - Require `in_ready`=0 in each WRITE cycle and no byte lost across WRITE.
- Bad checksum: N=1, AA, BB, CC, CHK=00.
  - Require the write to occur, then `err`=1, `done`=0, `cpu_hold`=1.
  - A second `start` must clear `err`.
- N=0 wrap: 256 words with data equal to the address.
  - Require 256 writes covering addresses 00 through FF with no extra write.
  - Require `done`=1 with a correct CHK.
- Ignored start: pulse `start` during BYTE of an N=3 load. Require no restart, addresses 00–02 written, and `busy` continuous.
